// File: rtl/driver_alu_if.sv
// ALU opcode package and the driver's stimulus bus (enable in, vector/status out).
// Header note: the driver's directed phase is gated by the DRIVER_ALU_DIRECTED_EN macro.
package rv32i_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALUSel_e;
endpackage

// Handshake: the consumer raises i_en to pull the next vector; o_valid marks
// registered outputs holding a generated vector, and they stay put while i_en is low.
interface driver_alu_if;
  import rv32i_pkg::*;
  logic        i_en;
  logic [31:0] o_operand_a;
  logic [31:0] o_operand_b;
  ALUSel_e     o_alu_op;
  logic        o_valid;
  logic        o_done;
  logic [31:0] o_vec_cnt;

  modport master (
    input  i_en,
    output o_operand_a, o_operand_b, o_alu_op, o_valid, o_done, o_vec_cnt
  );
  modport slave (
    output i_en,
    input  o_operand_a, o_operand_b, o_alu_op, o_valid, o_done, o_vec_cnt
  );
endinterface

// File: rtl/driver_alu.sv
// ALU stimulus driver: corner sweep (when DRIVER_ALU_DIRECTED_EN is defined), then
// NUM_RANDOM Galois-LFSR vectors, then a sticky done flag. o_state exposes the FSM.
module driver_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned NUM_RANDOM = 1000,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  driver_alu_if.master bus,
  output logic [1:0]   o_state
);
  typedef enum logic [1:0] {
    ST_DIRECTED = 2'd0,
    ST_RANDOM   = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
`ifdef DRIVER_ALU_DIRECTED_EN
  localparam state_e ST_RESET = ST_DIRECTED;
`else
  // With no directed phase and no random vectors there is nothing to issue.
  localparam state_e ST_RESET = (NUM_RANDOM == 0) ? ST_DONE : ST_RANDOM;
`endif

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_next;
  logic [31:0] rnd_cnt_q, rnd_cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d;
  ALUSel_e     op_q, op_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic [3:0]  rnd_n, rnd_op;

`ifdef DRIVER_ALU_DIRECTED_EN
  // Directed index k split into nested counters: b fastest, then a, then op.
  logic [2:0] b_idx_q, b_idx_d, a_idx_q, a_idx_d;
  logic [3:0] op_idx_q, op_idx_d;

  function automatic logic [31:0] corner(input logic [2:0] idx);
    case (idx)
      3'd0:    corner = 32'h0000_0000;
      3'd1:    corner = 32'h0000_0001;
      3'd2:    corner = 32'h7FFF_FFFF;
      3'd3:    corner = 32'h8000_0000;
      3'd4:    corner = 32'hFFFF_FFFF;
      default: corner = 32'h0000_001F;
    endcase
  endfunction
`endif

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    rnd_n     = lfsr_next[3:0];
    rnd_op    = (rnd_n < 4'd10) ? rnd_n : (rnd_n - 4'd10);

    state_d   = state_q;
    lfsr_d    = lfsr_q;
    rnd_cnt_d = rnd_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    valid_d   = valid_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
`ifdef DRIVER_ALU_DIRECTED_EN
    b_idx_d   = b_idx_q;
    a_idx_d   = a_idx_q;
    op_idx_d  = op_idx_q;
`endif

    if (bus.i_en) begin
      case (state_q)
`ifdef DRIVER_ALU_DIRECTED_EN
        ST_DIRECTED: begin
          a_d     = corner(a_idx_q);
          b_d     = corner(b_idx_q);
          op_d    = ALUSel_e'(op_idx_q);
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          if (b_idx_q == 3'd5) begin
            b_idx_d = 3'd0;
            if (a_idx_q == 3'd5) begin
              a_idx_d = 3'd0;
              if (op_idx_q == 4'd9) begin
                op_idx_d = 4'd0;
                state_d  = (NUM_RANDOM == 0) ? ST_DONE : ST_RANDOM;
              end else begin
                op_idx_d = op_idx_q + 4'd1;
              end
            end else begin
              a_idx_d = a_idx_q + 3'd1;
            end
          end else begin
            b_idx_d = b_idx_q + 3'd1;
          end
        end
`endif
        ST_RANDOM: begin
          lfsr_d    = lfsr_next;
          a_d       = lfsr_next;
          b_d       = {lfsr_next[15:0], lfsr_next[31:16]};
          op_d      = ALUSel_e'(rnd_op);
          valid_d   = 1'b1;
          cnt_d     = cnt_q + 32'd1;
          rnd_cnt_d = rnd_cnt_q + 32'd1;
          if (rnd_cnt_q == NUM_RANDOM - 32'd1) state_d = ST_DONE;
        end
        ST_DONE: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RESET;
      lfsr_q    <= SEED_EFF;
      rnd_cnt_q <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= ALU_ADD;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 32'd0;
`ifdef DRIVER_ALU_DIRECTED_EN
      b_idx_q   <= 3'd0;
      a_idx_q   <= 3'd0;
      op_idx_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rnd_cnt_q <= rnd_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
`ifdef DRIVER_ALU_DIRECTED_EN
      b_idx_q   <= b_idx_d;
      a_idx_q   <= a_idx_d;
      op_idx_q  <= op_idx_d;
`endif
    end
  end

  assign bus.o_operand_a = a_q;
  assign bus.o_operand_b = b_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_done      = done_q;
  assign bus.o_vec_cnt   = cnt_q;
  assign o_state         = state_q;
endmodule

// File: tb/tb_driver_alu.sv
// Bench for driver_alu: spec-derived vector table, arithmetic reference model,
// stall, mid-run async reset with replay, and completion on a short instance.
module tb_driver_alu;
  import rv32i_pkg::*;

  localparam int NR_A = 60;
  localparam int NR_B = 4;
`ifdef DRIVER_ALU_DIRECTED_EN
  localparam int DIR_N     = 360;
  localparam int STALL_IDX = 100;
`else
  localparam int DIR_N     = 0;
  localparam int STALL_IDX = 10;
`endif
  localparam int TOT_A  = DIR_N + NR_A;
  localparam int TOT_B  = DIR_N + NR_B;
  localparam int PART_A = DIR_N + 45;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        valid;
    logic        done;
    logic [31:0] cnt;
  } obs_t;

  logic        clk;
  logic        rst_n_a, rst_n_b;
  logic [1:0]  st_a, st_b;
  int          checks, failures;
  logic [31:0] corner_v [6];
  logic [31:0] lfsr_tab [128];
  vec_t        tbl [8];
  int          n_tbl;
  obs_t        cap [40];

  driver_alu_if bus_a ();
  driver_alu_if bus_b ();

  driver_alu #(.NUM_RANDOM(NR_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .bus(bus_a), .o_state(st_a)
  );
  driver_alu #(.NUM_RANDOM(NR_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n_b), .bus(bus_b), .o_state(st_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: vector number idx computed directly from the sweep/LFSR rules.
  function automatic void ref_vec(input int idx, output logic [31:0] a,
                                  output logic [31:0] b, output logic [3:0] op);
    logic [31:0] s;
    int n;
    if (idx < 0) begin
      a = 32'h0; b = 32'h0; op = 4'd0;
    end else if (idx < DIR_N) begin
      op = 4'(idx / 36);
      a  = corner_v[(idx / 6) % 6];
      b  = corner_v[idx % 6];
    end else begin
      s  = lfsr_tab[idx - DIR_N + 1];
      a  = s;
      b  = {s[15:0], s[31:16]};
      n  = int'(s[3:0]);
      op = 4'((n < 10) ? n : n - 10);
    end
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.a = bus_a.o_operand_a; o.b = bus_a.o_operand_b; o.op = 4'(bus_a.o_alu_op);
    o.valid = bus_a.o_valid; o.done = bus_a.o_done; o.cnt = bus_a.o_vec_cnt;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.a = bus_b.o_operand_a; o.b = bus_b.o_operand_b; o.op = 4'(bus_b.o_alu_op);
    o.valid = bus_b.o_valid; o.done = bus_b.o_done; o.cnt = bus_b.o_vec_cnt;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_obs(input string tag, input obs_t o, input int idx,
                            input logic valid, input logic done, input logic [31:0] cnt);
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    ref_vec(idx, ea, eb, eop);
    check({tag, "_a"}, o.a, ea);
    check({tag, "_b"}, o.b, eb);
    check({tag, "_op"}, 32'(o.op), 32'(eop));
    check({tag, "_valid"}, 32'(o.valid), 32'(valid));
    check({tag, "_done"}, 32'(o.done), 32'(done));
    check({tag, "_cnt"}, o.cnt, cnt);
  endtask

  task automatic adv_a();
    @(negedge clk);
    bus_a.i_en = 1'b1;
    @(posedge clk);
    #1;
    bus_a.i_en = 1'b0;
  endtask

  task automatic adv_b();
    @(negedge clk);
    bus_b.i_en = 1'b1;
    @(posedge clk);
    #1;
    bus_b.i_en = 1'b0;
  endtask

  initial begin
    obs_t o;
    checks = 0;
    failures = 0;
    bus_a.i_en = 1'b0;
    bus_b.i_en = 1'b0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;

    corner_v[0] = 32'h0000_0000; corner_v[1] = 32'h0000_0001;
    corner_v[2] = 32'h7FFF_FFFF; corner_v[3] = 32'h8000_0000;
    corner_v[4] = 32'hFFFF_FFFF; corner_v[5] = 32'h0000_001F;
    lfsr_tab[0] = 32'hACE1_2468;
    for (int i = 1; i < 128; i++)
      lfsr_tab[i] = (lfsr_tab[i-1] >> 1) ^ (lfsr_tab[i-1][0] ? 32'h8020_0003 : 32'h0);

`ifdef DRIVER_ALU_DIRECTED_EN
    tbl[0] = '{0,   32'h0000_0000, 32'h0000_0000, 4'd0};
    tbl[1] = '{6,   32'h0000_0001, 32'h0000_0000, 4'd0};
    tbl[2] = '{35,  32'h0000_001F, 32'h0000_001F, 4'd0};
    tbl[3] = '{36,  32'h0000_0000, 32'h0000_0000, 4'd1};
    tbl[4] = '{100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2};
    tbl[5] = '{101, 32'hFFFF_FFFF, 32'h0000_001F, 4'd2};
    tbl[6] = '{359, 32'h0000_001F, 32'h0000_001F, 4'd9};
    tbl[7] = '{360, 32'h5670_9234, 32'h9234_5670, 4'd4};
    n_tbl  = 8;
`else
    tbl[0] = '{0, 32'h5670_9234, 32'h9234_5670, 4'd4};
    n_tbl  = 1;
`endif

    #12;
    expect_obs("rst_a", obs_a(), -1, 1'b0, 1'b0, 32'd0);
    expect_obs("rst_b", obs_b(), -1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // First run into the random phase, with a stall and table spot-checks.
    for (int i = 0; i < PART_A; i++) begin
      adv_a();
      o = obs_a();
      expect_obs($sformatf("run1_v%0d", i), o, i, 1'b1, 1'b0, 32'(i + 1));
      if (i < 40) cap[i] = o;
      for (int t = 0; t < n_tbl; t++) begin
        if (tbl[t].idx == i) begin
          check($sformatf("tbl%0d_a", i), o.a, tbl[t].a);
          check($sformatf("tbl%0d_b", i), o.b, tbl[t].b);
          check($sformatf("tbl%0d_op", i), 32'(o.op), 32'(tbl[t].op));
        end
      end
      if (i == STALL_IDX) begin
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          #1;
          expect_obs($sformatf("stall%0d", s), obs_a(), STALL_IDX, 1'b1, 1'b0,
                     32'(STALL_IDX + 1));
        end
      end
    end

    // Asynchronous reset between clock edges, then a full replay to completion.
    #2;
    rst_n_a = 1'b0;
    #1;
    expect_obs("midrst", obs_a(), -1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int i = 0; i < TOT_A; i++) begin
      adv_a();
      o = obs_a();
      expect_obs($sformatf("run2_v%0d", i), o, i, 1'b1, 1'b0, 32'(i + 1));
      if (i < 40) begin
        check($sformatf("replay%0d_a", i), o.a, cap[i].a);
        check($sformatf("replay%0d_b", i), o.b, cap[i].b);
        check($sformatf("replay%0d_op", i), 32'(o.op), 32'(cap[i].op));
      end
    end
    for (int i = 0; i < 4; i++) begin
      adv_a();
      expect_obs($sformatf("done_a%0d", i), obs_a(), TOT_A - 1, 1'b0, 1'b1, 32'(TOT_A));
    end

    // Short instance: completion right after the last random vector.
    for (int i = 0; i < TOT_B; i++) begin
      adv_b();
      expect_obs($sformatf("b_v%0d", i), obs_b(), i, 1'b1, 1'b0, 32'(i + 1));
    end
    for (int i = 0; i < 11; i++) begin
      adv_b();
      expect_obs($sformatf("done_b%0d", i), obs_b(), TOT_B - 1, 1'b0, 1'b1, 32'(TOT_B));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/driver_alu.md
# driver_alu

Stimulus driver for the ALU bench: generates the operand/opcode stream that feeds the ALU under test and its golden-model scoreboard. It runs a deterministic corner-value sweep over every opcode, then a seeded pseudo-random phase, then stops and flags completion. Outputs are registered and hold steady while the bench stalls, so a combinational ALU and scoreboard can check every cycle.

## Interface

- NUM_RANDOM, 1000: number of random-phase vectors; 0 is legal.
- SEED, 32'hACE1_2468: LFSR reset value; a SEED of 0 is replaced internally by 32'h0000_0001.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  advance enable; 0 = stall.
- o_operand_a  out  32  operand A to the ALU and scoreboard.
- o_operand_b  out  32  operand B to the ALU and scoreboard.
- o_alu_op  out  ALUSel_e (4)  opcode, from rv32i_pkg: ADD=0 through SLTU=9.
- o_valid  out  1  current outputs hold a generated vector.
- o_done  out  1  sequence complete; sticky until reset.
- o_vec_cnt  out  32  number of vectors issued.

## Operation

- FSM states and transitions:
  - ST_DIRECTED -> ST_RANDOM after vector index 359.
  - ST_RANDOM -> ST_DONE after NUM_RANDOM vectors.
  - If NUM_RANDOM = 0, ST_DIRECTED -> ST_DONE directly.
- Reset values:
  - Operands 0, o_alu_op = ALU_ADD.
  - o_valid = 0, o_done = 0, o_vec_cnt = 0.
  - Directed index k = 0, LFSR = SEED.
  - State = ST_DIRECTED, or ST_RANDOM when the macro is off.
- Corner table C[0..5] = {32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F}.
- Directed vector k (0..359):
  - op = k/36.
  - a = C[(k/6)%6].
  - b = C[k%6].
  - Order: b varies fastest, then a, then op.
- Random vector:
  - LFSR steps once per vector, right-shift Galois form: s' = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
  - a = s'.
  - b = {s'[15:0], s'[31:16]}.
  - n = s'[3:0]; op = n if n < 10, else n-10.
- Each enabled cycle in ST_DIRECTED or ST_RANDOM:
  - Register the next vector.
  - o_valid = 1.
  - o_vec_cnt += 1.
- First enabled cycle in ST_DONE:
  - o_valid = 0, o_done = 1.
  - Operands and op hold the last vector.
  - o_vec_cnt frozen.
- i_en = 0: every output, the FSM, k and the LFSR hold.

## Timing

- Latency: one cycle. A vector appears on the rising edge that samples i_en = 1.
- The first vector appears on the first enabled edge after reset release.
- Completion: o_done rises on the enabled edge after the last vector, i.e. at vector count 360+NUM_RANDOM (NUM_RANDOM with the macro off).
- Reset mid-operation:
  - Outputs drop to their reset values immediately (asynchronous).
  - After release, the sequence replays bit-identically from vector 0.
- In ST_DONE, i_en has no further effect.

## Configuration

- DRIVER_ALU_DIRECTED_EN defined:
  - Directed phase (360 vectors) is compiled in.
  - Reset state is ST_DIRECTED.
- DRIVER_ALU_DIRECTED_EN undefined:
  - Directed logic and table are removed.
  - Reset state is ST_RANDOM; the first vector is the first LFSR vector.
  - Total vectors = NUM_RANDOM.

## Test plan

- Reset, then i_en = 1 -> first edge gives a = 0, b = 0, op = ALU_ADD, o_valid = 1, o_vec_cnt = 1.
- Directed sweep:
  - k = 6 -> a = 1, b = 0, op = ADD.
  - k = 35 -> a = 32'h1F, b = 32'h1F, op = ADD.
  - k = 36 -> a = 0, b = 0, op = ALU_SUB.
  - k = 359 -> a = b = 32'h1F, op = ALU_SLTU.
- Stall: drop i_en for 5 cycles after k = 100 -> all outputs and o_vec_cnt unchanged; the next enabled edge gives k = 101.
- Random phase, default SEED:
  - First random vector: a = 32'h5670_9234, b = 32'h9234_5670, op = ALU_AND (4).
  - With the macro off, this is vector 1.
- NUM_RANDOM = 4:
  - After 364 vectors, the next edge gives o_valid = 0 and o_done = 1.
  - o_vec_cnt = 364 holds for 10 further cycles.
- Reset pulse mid random phase:
  - Outputs go to 0/ADD/valid 0 without waiting for a clock.
  - After release, the first 40 vectors match the first run exactly.
